// File: rtl/obc_shift_accumulator.sv
// OBC shift-accumulator: folds four ROM partial words per bit slice,
// MSB slice negated, then adds the offset term and hands off one result.
module obc_shift_accumulator #(
  parameter int DATA_W = 32,
  parameter int N_BITS = 16,
  parameter int ACC_W  = DATA_W + N_BITS + 2,
  localparam int IDX_W = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] rom_in0,
  input  logic [DATA_W-1:0] rom_in1,
  input  logic [DATA_W-1:0] rom_in2,
  input  logic [DATA_W-1:0] rom_in3,
  input  logic [DATA_W-1:0] offset_in,
  output logic [IDX_W-1:0]  slice_idx,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OFFSET,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] TOP = IDX_W'(N_BITS - 1);

  state_t            state, state_d;
  logic [ACC_W-1:0]  acc, acc_d;
  logic [ACC_W-1:0]  result_d;
  logic [IDX_W-1:0]  idx_d;
  logic [DATA_W+1:0] psum;
  logic [ACC_W-1:0]  psum_x;
  logic [ACC_W-1:0]  off_x;
  logic [ACC_W-1:0]  off_sum;

  function automatic logic [DATA_W+1:0] sx(input logic [DATA_W-1:0] w);
    return {{2{w[DATA_W-1]}}, w};
  endfunction

  assign psum    = sx(rom_in0) + sx(rom_in1) + sx(rom_in2) + sx(rom_in3);
  assign psum_x  = {{(ACC_W-DATA_W-2){psum[DATA_W+1]}}, psum};
  assign off_x   = {{(ACC_W-DATA_W){offset_in[DATA_W-1]}}, offset_in}
                   << (N_BITS - 1);
  assign off_sum = acc + off_x;

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    idx_d    = slice_idx;
    result_d = result;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          idx_d   = TOP;
        end
      end
      ACCUM: begin
        // MSB slice carries negative weight in two's complement
        if (slice_idx == TOP) acc_d = -psum_x;
        else                  acc_d = (acc << 1) + psum_x;
        idx_d = slice_idx - IDX_W'(1);
        if (slice_idx == '0) begin
          state_d = OFFSET;
          idx_d   = TOP;
        end
      end
      OFFSET: begin
        acc_d    = off_sum;
        result_d = off_sum;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            state_d = ACCUM;
            acc_d   = '0;
            idx_d   = TOP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      result    <= '0;
      slice_idx <= TOP;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      result    <= result_d;
      slice_idx <= idx_d;
    end
  end

  assign busy      = (state == ACCUM) || (state == OFFSET);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Bench for obc_shift_accumulator: ROM tables driven from slice_idx,
// results checked against a weighted-sum reference model.
module tb_obc_shift_accumulator;

  localparam int DATA_W = 32;
  localparam int N_BITS = 16;
  localparam int ACC_W  = DATA_W + N_BITS + 2;
  localparam int IDX_W  = $clog2(N_BITS);
  localparam int LAT    = N_BITS + 2;

  logic              clk = 0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] rom_in0, rom_in1, rom_in2, rom_in3;
  logic [DATA_W-1:0] offset_in;
  logic [IDX_W-1:0]  slice_idx;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;

  logic [DATA_W-1:0] tbl [4][N_BITS];

  int n_chk  = 0;
  int n_pass = 0;

  obc_shift_accumulator #(
    .DATA_W(DATA_W),
    .N_BITS(N_BITS),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rom_in0  (rom_in0),
    .rom_in1  (rom_in1),
    .rom_in2  (rom_in2),
    .rom_in3  (rom_in3),
    .offset_in(offset_in),
    .slice_idx(slice_idx),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  always #5 clk = ~clk;

  // combinational ROM banks addressed by the current slice
  always_comb begin
    rom_in0 = tbl[0][slice_idx];
    rom_in1 = tbl[1][slice_idx];
    rom_in2 = tbl[2][slice_idx];
    rom_in3 = tbl[3][slice_idx];
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint res_val();
    return longint'($signed(result));
  endfunction

  // sum over slices of S[b]*2^b, MSB weight negative, plus offset*2^(N-1)
  function automatic longint model(input logic [DATA_W-1:0] off);
    longint acc, s;
    acc = 0;
    for (int b = 0; b < N_BITS; b++) begin
      s = 0;
      for (int j = 0; j < 4; j++) s += longint'($signed(tbl[j][b]));
      if (b == N_BITS - 1) s = -s;
      acc += s * (longint'(1) << b);
    end
    return acc + longint'($signed(off)) * (longint'(1) << (N_BITS - 1));
  endfunction

  task automatic fill(input logic [DATA_W-1:0] v);
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < N_BITS; b++) tbl[j][b] = v;
  endtask

  // called at the negedge right after the start edge
  task automatic wait_valid(input string tag);
    int n;
    n = 1;
    while (!out_valid && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, LAT);
  endtask

  task automatic pop();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic run(input string tag, input longint exp);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_valid(tag);
    check({tag, "_res"}, res_val(), exp);
    pop();
    check({tag, "_drop"}, longint'(out_valid), 0);
  endtask

  initial begin
    longint r0;
    int n;
    rst = 1;
    start = 0;
    out_ready = 0;
    offset_in = '0;
    fill('0);
    repeat (2) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_idx", longint'(slice_idx), N_BITS - 1);
    check("rst_res", res_val(), 0);
    rst = 0;
    @(negedge clk);

    fill(32'd1);
    run("t1", -4);

    fill('0);
    offset_in = 32'd5;
    run("t2", 163840);

    offset_in = '0;
    tbl[0][N_BITS-1] = 32'd8;
    run("t3", -262144);

    fill(32'h7FFF_FFFF);
    run("t4", -64'sd8589934588);

    // T5: stall with start pulses, then back-to-back restart
    fill(32'd3);
    offset_in = 32'hFFFF_FFFE;
    r0 = model(offset_in);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_valid("t5");
    check("t5_res", res_val(), r0);
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      @(negedge clk);
      check("t5_hold_v", longint'(out_valid), 1);
      check("t5_hold_r", res_val(), r0);
      check("t5_hold_b", longint'(busy), 0);
    end
    start = 1;
    out_ready = 1;
    @(negedge clk);
    start = 0;
    out_ready = 0;
    check("t5_b2b_busy", longint'(busy), 1);
    check("t5_b2b_v", longint'(out_valid), 0);
    check("t5_b2b_idx", longint'(slice_idx), N_BITS - 1);
    wait_valid("t5b");
    check("t5b_res", res_val(), r0);
    pop();

    // T6: reset mid-accumulation
    fill(32'd9);
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (slice_idx != 4'd7 && n < LAT) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach7", longint'(slice_idx), 7);
    rst = 1;
    start = 1;
    @(negedge clk);
    rst = 0;
    start = 0;
    check("t6_busy", longint'(busy), 0);
    check("t6_valid", longint'(out_valid), 0);
    check("t6_idx", longint'(slice_idx), N_BITS - 1);
    @(negedge clk);
    check("t6_idle", longint'(busy), 0);
    fill(32'd1);
    offset_in = '0;
    run("t6_t1", -4);

    // randomized tables against the reference model
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 4; j++)
        for (int b = 0; b < N_BITS; b++)
          case ($urandom_range(0, 5))
            0:       tbl[j][b] = 32'h8000_0000;
            1:       tbl[j][b] = 32'h7FFF_FFFF;
            default: tbl[j][b] = $urandom();
          endcase
      offset_in = $urandom();
      run($sformatf("rnd%0d", k), model(offset_in));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
